de_mw_hazard_ctrl: RTL and testbench
====================================

// Module: de_mw_hazard_ctrl
// PURPOSE
//   Hazard and forwarding controller for the 3-stage (F / DE / MW) RV32I pipeline. Holds the
//   DE->MW control pipeline register and compares DE source registers against the MW destination.
//   Drives the 1-bit ForwardAE/ForwardBE selects of the DE forwarding muxes, the fetch and IF/DE
//   stall/flush controls, and a saturating stall-cycle counter for performance debug.
// PARAMETERS
//   REG_AW  5   register address width
//   CNT_W   16  width of stall_cycles counter
// PORTS
//   clk          in   1       pipeline clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   valid_de     in   1       DE holds a real instruction (not a bubble)
//   rs1_de       in   REG_AW  DE source register 1
//   rs2_de       in   REG_AW  DE source register 2
//   rd_de        in   REG_AW  DE destination register
//   reg_wr_de    in   1       DE instruction writes rd
//   is_load_de   in   1       DE instruction is a load (result only available at end of MW)
//   br_taken_de  in   1       DE branch/jump resolved taken (PC redirect)
//   mem_busy_mw  in   1       data memory not ready, MW must hold
//   ForwardAE    out  1       1: SrcA = ALUResult from MW, 0: rdata1
//   ForwardBE    out  1       1: SrcB = ALUResult from MW, 0: rdata2
//   stall_f      out  1       hold PC and IF/DE register
//   stall_de     out  1       DE instruction must not advance
//   flush_de     out  1       load bubble into IF/DE at next edge
//   valid_mw     out  1       MW holds a real instruction
//   rd_mw        out  REG_AW  MW destination register
//   reg_wr_mw    out  1       MW instruction writes rd
//   is_load_mw   out  1       MW instruction is a load
//   stall_cycles out  CNT_W   count of cycles with stall_f=1, saturating
// BEHAVIOUR
//   Reset: valid_mw, rd_mw, reg_wr_mw, is_load_mw, stall_cycles = 0; state = RUN.
//   Combinational outputs therefore reset to ForwardAE/BE=0, stall_f/stall_de/flush_de=0.
//   hit_x = valid_mw & reg_wr_mw & (rd_mw != 0) & valid_de & (rs_x_de == rd_mw).
//   Forwarding: ForwardAE = hit_1 & ~is_load_mw; ForwardBE = hit_2 & ~is_load_mw. x0 never forwards.
//   load_use = (hit_1 | hit_2) & is_load_mw.
//   Priority per cycle: mem_busy_mw > load_use > br_taken_de.
//   State RUN (normal flow):
//     - mem_busy_mw=1: stall_f=stall_de=1, MW register holds, go MEM_WAIT.
//     - load_use=1: stall_f=stall_de=1; MW register loads a bubble (valid_mw<=0); go LD_BUBBLE.
//       br_taken_de is ignored this cycle (operands invalid).
//     - br_taken_de & valid_de: flush_de=1, stall_f=0; DE advances to MW normally.
//     - else: MW register <= {valid_de, rd_de, reg_wr_de, is_load_de}.
//   State MEM_WAIT: stall_f=stall_de=1 and MW holds while mem_busy_mw=1; when it drops, evaluate
//     as RUN in the same cycle and return to RUN. Forward selects stay valid throughout.
//   State LD_BUBBLE: load wrote back at the previous edge (regfile write-first); evaluate as RUN
//     (no hazard remains since valid_mw=0) and return to RUN. Exactly one stall cycle per load-use.
//   flush_de and stall_f are never both 1.
//   stall_cycles increments on every cycle with stall_f=1, saturates at 2^CNT_W-1 (no wrap).
//   Reset mid-stall: all state cleared immediately; pipeline resumes in RUN on rst_n release.
// TESTING
//   1) add x5 in MW, DE "sub x6,x5,x1" -> ForwardAE=1, ForwardBE=0, no stall.
//   2) lw x7 in MW, DE "add x8,x2,x7" -> stall_f=stall_de=1 one cycle, then valid_mw=0,
//      ForwardBE=0, add proceeds; stall_cycles +1.
//   3) MW writes x0, DE reads x0 -> ForwardAE=ForwardBE=0.
//   4) DE beq taken with no hazard -> flush_de=1 for 1 cycle; with concurrent load_use ->
//      flush_de=0, stall first, flush on next cycle.
//   5) mem_busy_mw high 3 cycles -> stall_f=1 for 3 cycles, MW fields unchanged, counter +3.
//   6) CNT_W=4, force 20 stall cycles -> stall_cycles=15; assert rst_n=0 during LD_BUBBLE ->
//      all outputs 0 immediately.

Source files
------------

// File: rtl/de_mw_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// de_mw_hazard_ctrl
//
// Hazard and forwarding controller for a 3-stage (F / DE / MW) RV32I pipeline.
// It owns the DE->MW control pipeline register (valid, rd, reg_wr, is_load).
// It compares the DE source registers against the MW destination to drive the
// DE forwarding-mux selects, and it generates the fetch and IF/DE stall and
// flush controls. A saturating counter records how many cycles fetch was
// stalled, for performance debug.
//
// Parameters
//   REG_AW        register address width
//   CNT_W         width of the stall_cycles counter
//
// Ports
//   clk           pipeline clock, rising edge
//   rst_n         asynchronous active-low reset
//   valid_de      DE holds a real instruction (not a bubble)
//   rs1_de/rs2_de DE source registers
//   rd_de         DE destination register
//   reg_wr_de     DE instruction writes rd
//   is_load_de    DE instruction is a load
//   br_taken_de   DE branch/jump resolved taken
//   mem_busy_mw   data memory not ready, MW must hold
//   ForwardAE/BE  1: take ALUResult from MW for SrcA/SrcB, 0: register file
//   stall_f       hold PC and the IF/DE register
//   stall_de      DE instruction must not advance
//   flush_de      load a bubble into IF/DE at the next edge
//   valid_mw, rd_mw, reg_wr_mw, is_load_mw   MW control register contents
//   stall_cycles  saturating count of cycles with stall_f = 1
// -----------------------------------------------------------------------------
module de_mw_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_de,
  input  logic [REG_AW-1:0] rs1_de,
  input  logic [REG_AW-1:0] rs2_de,
  input  logic [REG_AW-1:0] rd_de,
  input  logic              reg_wr_de,
  input  logic              is_load_de,
  input  logic              br_taken_de,
  input  logic              mem_busy_mw,
  output logic              ForwardAE,
  output logic              ForwardBE,
  output logic              stall_f,
  output logic              stall_de,
  output logic              flush_de,
  output logic              valid_mw,
  output logic [REG_AW-1:0] rd_mw,
  output logic              reg_wr_mw,
  output logic              is_load_mw,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    LD_BUBBLE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic mw_writes;
  logic hit_1;
  logic hit_2;
  logic load_use;
  logic mw_hold;
  logic mw_bubble;

  // MW can only be a forwarding source if it really writes a non-zero
  // register; x0 is hard-wired to zero and must never be forwarded.
  assign mw_writes = valid_mw & reg_wr_mw & (rd_mw != '0) & valid_de;
  assign hit_1     = mw_writes & (rs1_de == rd_mw);
  assign hit_2     = mw_writes & (rs2_de == rd_mw);

  // A load result only exists at the end of MW, so it cannot be forwarded
  // into DE; a dependent DE instruction has to wait one cycle instead.
  assign ForwardAE = hit_1 & ~is_load_mw;
  assign ForwardBE = hit_2 & ~is_load_mw;
  assign load_use  = (hit_1 | hit_2) & is_load_mw;

  // Every state resolves the same priority (memory wait, then load-use,
  // then taken branch). MEM_WAIT simply keeps holding while memory is busy.
  // LD_BUBBLE always finds an empty MW, so it naturally falls through
  // to normal flow. The state register is kept to make the current
  // stall reason visible when debugging.
  always_comb begin
    stall_f   = 1'b0;
    stall_de  = 1'b0;
    flush_de  = 1'b0;
    mw_hold   = 1'b0;
    mw_bubble = 1'b0;
    state_nxt = RUN;

    unique case (state)
      RUN, MEM_WAIT, LD_BUBBLE: begin
        if (mem_busy_mw) begin
          stall_f   = 1'b1;
          stall_de  = 1'b1;
          mw_hold   = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (load_use) begin
          // Operands are not valid yet, so a taken branch this cycle is
          // ignored. It is re-resolved when the instruction retries.
          stall_f   = 1'b1;
          stall_de  = 1'b1;
          mw_bubble = 1'b1;
          state_nxt = LD_BUBBLE;
        end else if (br_taken_de && valid_de) begin
          flush_de  = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // DE->MW control register. A bubble clears every field rather than only
  // the valid bit. This keeps stale destination information out of MW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_mw   <= 1'b0;
      rd_mw      <= '0;
      reg_wr_mw  <= 1'b0;
      is_load_mw <= 1'b0;
    end else if (mw_hold) begin
      valid_mw   <= valid_mw;
      rd_mw      <= rd_mw;
      reg_wr_mw  <= reg_wr_mw;
      is_load_mw <= is_load_mw;
    end else if (mw_bubble) begin
      valid_mw   <= 1'b0;
      rd_mw      <= '0;
      reg_wr_mw  <= 1'b0;
      is_load_mw <= 1'b0;
    end else begin
      valid_mw   <= valid_de;
      rd_mw      <= rd_de;
      reg_wr_mw  <= reg_wr_de;
      is_load_mw <= is_load_de;
    end
  end

  // Stall-cycle counter. It sticks at all-ones instead of wrapping, so a
  // long run never reports a misleadingly small number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall_f && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_de_mw_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_de_mw_hazard_ctrl
//
// Self-checking bench for de_mw_hazard_ctrl. Two instances share all inputs:
// one uses the default 16-bit counter, and one uses a 4-bit counter to show
// saturation. A behavioural model written from the pipeline rules tracks the
// MW register and both counters. Directed scenarios and a randomized run are
// compared against that model.
// -----------------------------------------------------------------------------
module tb_de_mw_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic       valid_de;
  logic [4:0] rs1_de;
  logic [4:0] rs2_de;
  logic [4:0] rd_de;
  logic       reg_wr_de;
  logic       is_load_de;
  logic       br_taken_de;
  logic       mem_busy_mw;

  logic        ForwardAE, ForwardBE, stall_f, stall_de, flush_de;
  logic        valid_mw, reg_wr_mw, is_load_mw;
  logic [4:0]  rd_mw;
  logic [15:0] stall_cycles;

  logic        s_fa, s_fb, s_stall_f, s_stall_de, s_flush;
  logic        s_valid_mw, s_reg_wr_mw, s_is_load_mw;
  logic [4:0]  s_rd_mw;
  logic [3:0]  s_stall_cycles;

  int n_cmp;
  int n_fail;

  de_mw_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_de(valid_de),
    .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_de(rd_de),
    .reg_wr_de(reg_wr_de), .is_load_de(is_load_de),
    .br_taken_de(br_taken_de), .mem_busy_mw(mem_busy_mw),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_f(stall_f), .stall_de(stall_de), .flush_de(flush_de),
    .valid_mw(valid_mw), .rd_mw(rd_mw), .reg_wr_mw(reg_wr_mw),
    .is_load_mw(is_load_mw), .stall_cycles(stall_cycles)
  );

  de_mw_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .valid_de(valid_de),
    .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_de(rd_de),
    .reg_wr_de(reg_wr_de), .is_load_de(is_load_de),
    .br_taken_de(br_taken_de), .mem_busy_mw(mem_busy_mw),
    .ForwardAE(s_fa), .ForwardBE(s_fb),
    .stall_f(s_stall_f), .stall_de(s_stall_de), .flush_de(s_flush),
    .valid_mw(s_valid_mw), .rd_mw(s_rd_mw), .reg_wr_mw(s_reg_wr_mw),
    .is_load_mw(s_is_load_mw), .stall_cycles(s_stall_cycles)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: contents of MW and the two counters.
  logic       m_valid;
  logic [4:0] m_rd;
  logic       m_wr;
  logic       m_ld;
  int         m_cnt;
  int         m_cnt4;

  function automatic logic m_hit(input logic [4:0] rs);
    return m_valid && m_wr && (m_rd != 5'd0) && valid_de && (rs == m_rd);
  endfunction

  function automatic logic m_load_use();
    return (m_hit(rs1_de) || m_hit(rs2_de)) && m_ld;
  endfunction

  function automatic logic m_stall();
    return mem_busy_mw || m_load_use();
  endfunction

  function automatic logic m_flush();
    return !m_stall() && br_taken_de && valid_de;
  endfunction

  // Model update: memory wait holds MW, load-use inserts an empty slot, and
  // otherwise the DE instruction moves on. Stalled cycles are counted with
  // saturation.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_rd    <= 5'd0;
      m_wr    <= 1'b0;
      m_ld    <= 1'b0;
      m_cnt   <= 0;
      m_cnt4  <= 0;
    end else begin
      if (mem_busy_mw) begin
        m_valid <= m_valid;
      end else if (m_load_use()) begin
        m_valid <= 1'b0;
        m_rd    <= 5'd0;
        m_wr    <= 1'b0;
        m_ld    <= 1'b0;
      end else begin
        m_valid <= valid_de;
        m_rd    <= rd_de;
        m_wr    <= reg_wr_de;
        m_ld    <= is_load_de;
      end
      if (m_stall()) begin
        m_cnt  <= (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
        m_cnt4 <= (m_cnt4 < 15)    ? m_cnt4 + 1 : m_cnt4;
      end
    end
  end

  // Advances one clock; inputs are then changed on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives the DE-stage instruction fields.
  task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] d, input logic wr, input logic ld,
                               input logic br);
    valid_de    = v;
    rs1_de      = a;
    rs2_de      = b;
    rd_de       = d;
    reg_wr_de   = wr;
    is_load_de  = ld;
    br_taken_de = br;
  endtask

  // Reset values of all outputs.
  task automatic test_reset();
    rst_n = 1'b0;
    mem_busy_mw = 1'b0;
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    n_cmp++; if (valid_mw !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid_mw: got %b want 0", valid_mw); end
    n_cmp++; if (rd_mw !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_rd_mw: got %0d want 0", rd_mw); end
    n_cmp++; if ({reg_wr_mw, is_load_mw} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_wr_ld: got %b%b want 00", reg_wr_mw, is_load_mw); end
    n_cmp++; if (stall_cycles !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d want 0", stall_cycles); end
    n_cmp++; if ({ForwardAE, ForwardBE, stall_f, stall_de, flush_de} !== 5'b0) begin
      n_fail++; $display("[TB] FAIL reset_comb: got %b%b%b%b%b want 00000", ForwardAE, ForwardBE, stall_f, stall_de, flush_de);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ALU result in MW is forwarded to the matching DE source only.
  task automatic test_forward();
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if ({ForwardAE, ForwardBE} !== 2'b10) begin n_fail++; $display("[TB] FAIL fwd_a: got %b%b want 10", ForwardAE, ForwardBE); end
    n_cmp++; if ({stall_f, stall_de, flush_de} !== 3'b000) begin n_fail++; $display("[TB] FAIL fwd_nostall: got %b%b%b want 000", stall_f, stall_de, flush_de); end
    applyStimulus(1'b1, 5'd2, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if ({ForwardAE, ForwardBE} !== 2'b01) begin n_fail++; $display("[TB] FAIL fwd_b: got %b%b want 01", ForwardAE, ForwardBE); end
    tick();
  endtask

  // A load followed by a dependent instruction stalls for exactly one cycle.
  task automatic test_load_use();
    logic [15:0] cnt0;
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    cnt0 = stall_cycles;
    applyStimulus(1'b1, 5'd2, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if ({stall_f, stall_de} !== 2'b11) begin n_fail++; $display("[TB] FAIL lu_stall: got %b%b want 11", stall_f, stall_de); end
    n_cmp++; if ({ForwardBE, flush_de} !== 2'b00) begin n_fail++; $display("[TB] FAIL lu_fwd_flush: got %b%b want 00", ForwardBE, flush_de); end
    tick();
    #1;
    n_cmp++; if (valid_mw !== 1'b0) begin n_fail++; $display("[TB] FAIL lu_bubble: got %b want 0", valid_mw); end
    n_cmp++; if ({stall_f, ForwardBE} !== 2'b00) begin n_fail++; $display("[TB] FAIL lu_release: got %b%b want 00", stall_f, ForwardBE); end
    n_cmp++; if (stall_cycles !== cnt0 + 16'd1) begin n_fail++; $display("[TB] FAIL lu_cnt: got %0d want %0d", stall_cycles, cnt0 + 16'd1); end
    tick();
    #1;
    n_cmp++; if ({valid_mw, rd_mw} !== {1'b1, 5'd8}) begin n_fail++; $display("[TB] FAIL lu_advance: got %b/%0d want 1/8", valid_mw, rd_mw); end
    @(negedge clk);
  endtask

  // A write to x0 is never forwarded.
  task automatic test_x0();
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    n_cmp++; if ({ForwardAE, ForwardBE, stall_f} !== 3'b000) begin n_fail++; $display("[TB] FAIL x0_fwd: got %b%b%b want 000", ForwardAE, ForwardBE, stall_f); end
    tick();
  endtask

  // A taken branch flushes IF/DE. If a load-use hazard is present, the stall
  // comes first and the flush follows one cycle later.
  task automatic test_branch();
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
    #1;
    n_cmp++; if ({flush_de, stall_f} !== 2'b10) begin n_fail++; $display("[TB] FAIL br_flush: got %b%b want 10", flush_de, stall_f); end
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    n_cmp++; if ({flush_de, stall_f} !== 2'b01) begin n_fail++; $display("[TB] FAIL br_lu_first: got %b%b want 01", flush_de, stall_f); end
    tick();
    #1;
    n_cmp++; if ({flush_de, stall_f} !== 2'b10) begin n_fail++; $display("[TB] FAIL br_lu_then: got %b%b want 10", flush_de, stall_f); end
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // Memory wait holds MW for three cycles while forwarding stays valid.
  task automatic test_mem_busy();
    logic [15:0] cnt0;
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    cnt0 = stall_cycles;
    applyStimulus(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
    mem_busy_mw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({stall_f, stall_de, ForwardAE} !== 3'b111) begin n_fail++; $display("[TB] FAIL mb_stall%0d: got %b%b%b want 111", i, stall_f, stall_de, ForwardAE); end
      n_cmp++; if ({valid_mw, rd_mw, reg_wr_mw} !== {1'b1, 5'd12, 1'b1}) begin n_fail++; $display("[TB] FAIL mb_hold%0d: got %b/%0d/%b want 1/12/1", i, valid_mw, rd_mw, reg_wr_mw); end
      tick();
    end
    mem_busy_mw = 1'b0;
    #1;
    n_cmp++; if (stall_f !== 1'b0) begin n_fail++; $display("[TB] FAIL mb_release: got %b want 0", stall_f); end
    n_cmp++; if (stall_cycles !== cnt0 + 16'd3) begin n_fail++; $display("[TB] FAIL mb_cnt: got %0d want %0d", stall_cycles, cnt0 + 16'd3); end
    tick();
  endtask

  // The counter saturates, and a reset in LD_BUBBLE clears everything at once.
  task automatic test_saturation_and_reset();
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    mem_busy_mw = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    mem_busy_mw = 1'b0;
    #1;
    n_cmp++; if (s_stall_cycles !== 4'd15) begin n_fail++; $display("[TB] FAIL sat_cnt4: got %0d want 15", s_stall_cycles); end
    n_cmp++; if (stall_cycles !== 16'd20) begin n_fail++; $display("[TB] FAIL sat_cnt16: got %0d want 20", stall_cycles); end
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({valid_mw, rd_mw, reg_wr_mw, is_load_mw} !== 8'd0) begin n_fail++; $display("[TB] FAIL rst_mid_mw: got %b/%0d/%b/%b want 0", valid_mw, rd_mw, reg_wr_mw, is_load_mw); end
    n_cmp++; if ({ForwardAE, ForwardBE, stall_f, stall_de, flush_de} !== 5'b0) begin n_fail++; $display("[TB] FAIL rst_mid_comb: got %b%b%b%b%b want 0", ForwardAE, ForwardBE, stall_f, stall_de, flush_de); end
    n_cmp++; if ({stall_cycles, s_stall_cycles} !== 20'd0) begin n_fail++; $display("[TB] FAIL rst_mid_cnt: got %0d/%0d want 0/0", stall_cycles, s_stall_cycles); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Random instruction streams checked cycle by cycle against the model.
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) < 85), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 70),
                    ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 25));
      mem_busy_mw = ($urandom_range(0, 99) < 15);
      #1;
      n_cmp++; if (ForwardAE !== (m_hit(rs1_de) && !m_ld)) begin n_fail++; $display("[TB] FAIL rnd_fa@%0d: got %b want %b", i, ForwardAE, m_hit(rs1_de) && !m_ld); end
      n_cmp++; if (ForwardBE !== (m_hit(rs2_de) && !m_ld)) begin n_fail++; $display("[TB] FAIL rnd_fb@%0d: got %b want %b", i, ForwardBE, m_hit(rs2_de) && !m_ld); end
      n_cmp++; if ({stall_f, stall_de} !== {m_stall(), m_stall()}) begin n_fail++; $display("[TB] FAIL rnd_stall@%0d: got %b%b want %b", i, stall_f, stall_de, m_stall()); end
      n_cmp++; if (flush_de !== m_flush()) begin n_fail++; $display("[TB] FAIL rnd_flush@%0d: got %b want %b", i, flush_de, m_flush()); end
      n_cmp++; if ({valid_mw, rd_mw, reg_wr_mw, is_load_mw} !== {m_valid, m_rd, m_wr, m_ld}) begin
        n_fail++; $display("[TB] FAIL rnd_mw@%0d: got %b/%0d/%b/%b want %b/%0d/%b/%b", i, valid_mw, rd_mw, reg_wr_mw, is_load_mw, m_valid, m_rd, m_wr, m_ld);
      end
      n_cmp++; if (stall_cycles !== 16'(m_cnt)) begin n_fail++; $display("[TB] FAIL rnd_cnt@%0d: got %0d want %0d", i, stall_cycles, m_cnt); end
      n_cmp++; if (s_stall_cycles !== 4'(m_cnt4)) begin n_fail++; $display("[TB] FAIL rnd_cnt4@%0d: got %0d want %0d", i, s_stall_cycles, m_cnt4); end
      tick();
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    mem_busy_mw = 1'b0;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_forward();
    test_load_use();
    test_x0();
    test_branch();
    test_mem_busy();
    test_saturation_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
